// File: rtl/clockworks_pkg.sv
// Shared state encoding and default constants for the clockworks run/pause/step sequencer.
package clockworks_pkg;

    typedef enum logic [1:0] {
        CW_HOLD,
        CW_RUN,
        CW_PAUSE,
        CW_STEP
    } cw_state_t;

    localparam int CW_SLOW          = 0;
    localparam int CW_RESET_CYCLES  = 1024;
    localparam int CW_START_RUNNING = 1;
    localparam int CW_CNT_W         = 32;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detect for a raw async button.
// Latency: o_pulse is a single-cycle pulse 3 i_clk after i_btn rises; no backpressure.
module btn_edge_sync (
    input  logic i_clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_btn;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/clockworks_sequencer.sv
// Run/pause/single-step clock-enable generator with power-on reset hold for the core.
// Latency: button effects land 4 i_clk after the press; all outputs registered; no backpressure.
module clockworks_sequencer
    import clockworks_pkg::*;
#(
    parameter int SLOW          = CW_SLOW,
    parameter int RESET_CYCLES  = CW_RESET_CYCLES,
    parameter int START_RUNNING = CW_START_RUNNING,
    parameter int CNT_W         = CW_CNT_W
) (
    input  logic             i_clk,
    input  logic             rst,
    input  logic             i_run_btn,
    input  logic             i_step_btn,
    output logic             o_resetn,
    output logic             o_ce,
    output logic             o_running,
    output logic [CNT_W-1:0] o_ce_count
);

    localparam int PW = (SLOW > 0) ? SLOW : 1;
    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam logic [PW-1:0] PMASK     = PW'((1 << SLOW) - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(RESET_CYCLES);

    logic             w_run_p;
    logic             w_step_p;
    cw_state_t        r_state;
    cw_state_t        w_state_nxt;
    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    w_presc_nxt;
    logic [HW-1:0]    r_hold;
    logic             w_ce_nxt;
    logic             r_resetn;
    logic             r_ce;
    logic             r_running;
    logic [CNT_W-1:0] r_ce_count;

    btn_edge_sync u_run_sync (
        .i_clk   (i_clk),
        .rst     (rst),
        .i_btn   (i_run_btn),
        .o_pulse (w_run_p)
    );

    btn_edge_sync u_step_sync (
        .i_clk   (i_clk),
        .rst     (rst),
        .i_btn   (i_step_btn),
        .o_pulse (w_step_p)
    );

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            r_state   <= CW_HOLD;
            r_resetn  <= 1'b0;
            r_ce      <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_resetn  <= (w_state_nxt != CW_HOLD);
            r_ce      <= w_ce_nxt;
            r_running <= (w_state_nxt == CW_RUN);
        end
    end

    // Run press beats a simultaneous step press in PAUSE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CW_HOLD:  if (r_hold == HOLD_LAST)
                          w_state_nxt = (START_RUNNING != 0) ? CW_RUN : CW_PAUSE;
            CW_RUN:   if (w_run_p) w_state_nxt = CW_PAUSE;
            CW_PAUSE: if (w_run_p)       w_state_nxt = CW_RUN;
                      else if (w_step_p) w_state_nxt = CW_STEP;
            CW_STEP:  w_state_nxt = CW_PAUSE;
            default:  w_state_nxt = CW_HOLD;
        endcase
    end

    // A period that completes on the pausing edge does not emit o_ce.
    always_comb begin
        w_ce_nxt = (w_state_nxt == CW_STEP) ||
                   ((r_state == CW_RUN) && (w_state_nxt == CW_RUN) && (r_presc == PMASK));
        w_presc_nxt = r_presc;
        if (r_state == CW_RUN)
            w_presc_nxt = (r_presc + PW'(1)) & PMASK;
        else if (w_state_nxt == CW_RUN)
            w_presc_nxt = '0;
    end

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            r_presc    <= '0;
            r_hold     <= '0;
            r_ce_count <= '0;
        end else begin
            r_presc <= w_presc_nxt;
            if ((r_state == CW_HOLD) && (r_hold != HOLD_MAX))
                r_hold <= r_hold + HW'(1);
            if (w_ce_nxt)
                r_ce_count <= r_ce_count + CNT_W'(1);
        end
    end

    assign o_resetn   = r_resetn;
    assign o_ce       = r_ce;
    assign o_running  = r_running;
    assign o_ce_count = r_ce_count;

endmodule

// File: tb/tb_clockworks_sequencer.sv
// Self-checking bench: vector table for power-up/pause/step, hand sequences for resume, reset and wrap.
module tb_clockworks_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0, run_a = 1'b0, step_a = 1'b0;
    logic        a_resetn, a_ce, a_running;
    logic [31:0] a_cnt;
    logic        rst_b = 1'b0, run_b = 1'b0, step_b = 1'b0;
    logic        b_resetn, b_ce, b_running;
    logic [3:0]  b_cnt;
    logic        rst_c = 1'b0, run_c = 1'b0, step_c = 1'b0;
    logic        c_resetn, c_ce, c_running;
    logic [7:0]  c_cnt;

    clockworks_sequencer #(.SLOW(2), .RESET_CYCLES(8), .START_RUNNING(1), .CNT_W(32)) u_a (
        .i_clk(clk), .rst(rst_a), .i_run_btn(run_a), .i_step_btn(step_a),
        .o_resetn(a_resetn), .o_ce(a_ce), .o_running(a_running), .o_ce_count(a_cnt));

    clockworks_sequencer #(.SLOW(0), .RESET_CYCLES(4), .START_RUNNING(1), .CNT_W(4)) u_b (
        .i_clk(clk), .rst(rst_b), .i_run_btn(run_b), .i_step_btn(step_b),
        .o_resetn(b_resetn), .o_ce(b_ce), .o_running(b_running), .o_ce_count(b_cnt));

    clockworks_sequencer #(.SLOW(1), .RESET_CYCLES(3), .START_RUNNING(0), .CNT_W(8)) u_c (
        .i_clk(clk), .rst(rst_c), .i_run_btn(run_c), .i_step_btn(step_c),
        .o_resetn(c_resetn), .o_ce(c_ce), .o_running(c_running), .o_ce_count(c_cnt));

    int n_chk = 0;
    int n_err = 0;
    int q_a[$];
    int q_b[$];
    bit sb_a = 1'b0;
    bit sb_b = 1'b0;

    typedef struct {
        logic run;
        logic step;
        int   ncyc;
        logic resetn;
        logic ce;
        logic running;
        int   cnt;
    } vec_t;
    vec_t tbl[16];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Button held for one cycle, then wait until the FSM has acted on it (4 edges total).
    task automatic press_a(input logic r, input logic s);
        run_a  = r;
        step_a = s;
        tick(1);
        run_a  = 1'b0;
        step_a = 1'b0;
        tick(3);
    endtask

    always @(negedge clk) begin
        if (sb_a && a_ce) begin
            if (q_a.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_a: unexpected o_ce, count %0d expected none", a_cnt);
            end else begin
                chk("sb_a_cnt", a_cnt, q_a.pop_front());
            end
        end
        if (sb_b && b_ce) begin
            if (q_b.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_b: unexpected o_ce, count %0d expected none", b_cnt);
            end else begin
                chk("sb_b_cnt", b_cnt, q_b.pop_front());
            end
        end
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 0};
        tbl[3]  = '{1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1, 0};
        tbl[4]  = '{1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1, 1};
        tbl[5]  = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 2};
        tbl[7]  = '{1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 3};
        tbl[8]  = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 3};
        tbl[9]  = '{1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 3};
        tbl[10] = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 3};
        tbl[11] = '{1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0, 3};
        tbl[12] = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 3};
        tbl[13] = '{1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 3};
        tbl[14] = '{1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 4};
        tbl[15] = '{1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 4};

        tick(3);
        chk("rst_state_a", {a_resetn, a_ce, a_running, a_cnt}, 35'd0);

        rst_a = 1'b1;
        foreach (tbl[i]) begin
            run_a  = tbl[i].run;
            step_a = tbl[i].step;
            tick(tbl[i].ncyc);
            chk($sformatf("vec%0d", i), {a_resetn, a_ce, a_running, a_cnt},
                {tbl[i].resetn, tbl[i].ce, tbl[i].running, 32'(tbl[i].cnt)});
        end

        // Two more single steps from PAUSE, each must yield exactly one o_ce.
        sb_a = 1'b1;
        for (int k = 0; k < 2; k++) begin
            q_a.push_back(5 + k);
            press_a(1'b0, 1'b1);
            tick(2);
        end
        sb_a = 1'b0;
        chk("step_drain", q_a.size(), 0);
        chk("step_cnt", a_cnt, 6);
        chk("step_paused", a_running, 0);

        // Resume: first o_ce exactly 4 cycles after RUN is entered.
        press_a(1'b1, 1'b0);
        chk("resume_run", {a_running, a_ce, a_cnt}, {1'b1, 1'b0, 32'd6});
        for (int k = 1; k < 4; k++) begin
            tick(1);
            chk($sformatf("resume_quiet%0d", k), a_ce, 0);
        end
        tick(1);
        chk("resume_ce", {a_ce, a_cnt}, {1'b1, 32'd7});

        // Step press in RUN changes nothing.
        step_a = 1'b1;
        tick(1);
        step_a = 1'b0;
        tick(3);
        chk("step_in_run", {a_running, a_ce, a_cnt}, {1'b1, 1'b1, 32'd8});

        press_a(1'b1, 1'b0);
        chk("pause2", {a_running, a_ce, a_cnt}, {1'b0, 1'b0, 32'd8});

        // Simultaneous run+step in PAUSE: run wins, no step pulse.
        press_a(1'b1, 1'b1);
        chk("simul_run", {a_running, a_ce, a_cnt}, {1'b1, 1'b0, 32'd8});
        for (int k = 1; k < 4; k++) begin
            tick(1);
            chk($sformatf("simul_quiet%0d", k), a_ce, 0);
        end
        tick(1);
        chk("simul_ce", {a_ce, a_cnt}, {1'b1, 32'd9});

        // Async reset mid-RUN, taking effect without a clock edge.
        rst_a = 1'b0;
        #1;
        chk("arst_run", {a_resetn, a_ce, a_running, a_cnt}, 35'd0);
        rst_a = 1'b1;
        tick(7);
        chk("rehold_low", a_resetn, 0);
        tick(1);
        chk("rehold_high", {a_resetn, a_running}, 2'b11);

        // Async reset mid-STEP.
        press_a(1'b1, 1'b0);
        chk("pause3", a_running, 0);
        press_a(1'b0, 1'b1);
        chk("in_step", a_ce, 1);
        rst_a = 1'b0;
        #1;
        chk("arst_step", {a_resetn, a_ce, a_running, a_cnt}, 35'd0);

        // SLOW=0, CNT_W=4: o_ce every RUN cycle, count wraps 15 -> 0.
        chk("rst_state_b", {b_resetn, b_ce, b_running, b_cnt}, 7'd0);
        rst_b = 1'b1;
        for (int k = 1; k <= 18; k++) q_b.push_back(k % 16);
        sb_b = 1'b1;
        tick(22);
        @(negedge clk);
        #1;
        rst_b = 1'b0;
        sb_b = 1'b0;
        chk("wrap_drain", q_b.size(), 0);
        #1;
        chk("wrap_rst", b_cnt, 0);

        // START_RUNNING=0: PAUSE after hold, no o_ce.
        rst_c = 1'b1;
        tick(3);
        chk("pause_start", {c_resetn, c_running, c_ce}, 3'b100);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                tick(1);
                if (c_ce) seen++;
            end
            chk("pause_start_noce", seen, 0);
        end
        chk("pause_start_cnt", c_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
